// File: rtl/comparator_pkg.sv
// Shared constants and window type for the 6-input max comparator tree and its feeders.
// The comparator tree wrapper imports the same package so both sides agree on slot count and width.
package comparator_pkg;

  localparam int N_IN   = 6;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;

  typedef logic [DATA_W-1:0] window_t [N_IN];

  // Slots at or beyond the real sample count get the pad value when a window is closed.
  function automatic logic [N_IN-1:0] pad_mask_for(input logic [CNT_W-1:0] count);
    logic [N_IN-1:0] mask;
    for (int i = 0; i < N_IN; i++) begin
      mask[i] = (i >= int'(count));
    end
    return mask;
  endfunction

endpackage

// File: rtl/window_bank.sv
// N_IN x WIDTH register bank: per-slot writes for serial filling, or a bulk load that
// replaces every slot at once, substituting PAD_VALUE wherever pad_mask is set.
module window_bank
  import comparator_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data [N_IN],
  input  logic [N_IN-1:0]  pad_mask,
  output logic [WIDTH-1:0] slot [N_IN]
);

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_reg;

      // Bulk load wins over a per-slot write landing on the same edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (load) begin
          slot_reg <= pad_mask[gi] ? PAD_VALUE : load_data[gi];
        end else if (wr_en[gi]) begin
          slot_reg <= wr_data;
        end
      end

      assign slot[gi] = slot_reg;
    end
  endgenerate

endmodule

// File: rtl/comparator_window_loader.sv
// Serial-to-parallel window loader feeding the 6-input max comparator tree. A fill bank collects
// samples while a hold bank presents the last closed window; flush closes a partial window with padding.
module comparator_window_loader
  import comparator_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] PAD_VALUE = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIDTH-1:0] win_data_0,
  output logic [WIDTH-1:0] win_data_1,
  output logic [WIDTH-1:0] win_data_2,
  output logic [WIDTH-1:0] win_data_3,
  output logic [WIDTH-1:0] win_data_4,
  output logic [WIDTH-1:0] win_data_5,
  output logic [2:0]       win_count
);

  logic [CNT_W-1:0] fill_cnt_reg, fill_cnt_next;
  logic [CNT_W-1:0] win_count_reg, win_count_next;
  logic             flush_pend_reg, flush_pend_next;
  logic             win_valid_reg, win_valid_next;
  logic [CNT_W-1:0] cnt_after;
  logic             accept, free, close, transfer;
  logic [N_IN-1:0]  fill_we;
  logic [WIDTH-1:0] fill_slot [N_IN];
  logic [WIDTH-1:0] load_data [N_IN];
  logic [WIDTH-1:0] hold_slot [N_IN];

  // STALLED is fill_cnt==N_IN or flush_pend; both block new samples until the hold bank frees up.
  assign in_ready  = !rst && (fill_cnt_reg < CNT_W'(N_IN)) && !flush_pend_reg;
  assign accept    = in_valid && in_ready;
  assign cnt_after = fill_cnt_reg + CNT_W'(accept);
  assign free      = !win_valid_reg || win_ready;
  assign close     = (cnt_after == CNT_W'(N_IN)) || flush_pend_reg ||
                     (flush && (cnt_after != '0));
  assign transfer  = close && free;

  // A same-cycle accepted sample bypasses the fill bank so it lands in the window on the closing edge.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_bypass
      assign fill_we[gi]   = accept && (fill_cnt_reg == CNT_W'(gi));
      assign load_data[gi] = fill_we[gi] ? in_data : fill_slot[gi];
    end
  endgenerate

  always_comb begin
    fill_cnt_next   = fill_cnt_reg;
    flush_pend_next = flush_pend_reg;
    win_valid_next  = win_valid_reg;
    win_count_next  = win_count_reg;
    if (transfer) begin
      fill_cnt_next   = '0;
      flush_pend_next = 1'b0;
      win_valid_next  = 1'b1;
      win_count_next  = cnt_after;
    end else begin
      fill_cnt_next = cnt_after;
      if (flush && (cnt_after != '0)) begin
        flush_pend_next = 1'b1;
      end
      if (win_ready) begin
        win_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_reg   <= '0;
      flush_pend_reg <= 1'b0;
      win_valid_reg  <= 1'b0;
      win_count_reg  <= '0;
    end else begin
      fill_cnt_reg   <= fill_cnt_next;
      flush_pend_reg <= flush_pend_next;
      win_valid_reg  <= win_valid_next;
      win_count_reg  <= win_count_next;
    end
  end

  window_bank #(
    .WIDTH     (WIDTH),
    .PAD_VALUE (PAD_VALUE)
  ) u_fill_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (fill_we),
    .wr_data   (in_data),
    .load      (1'b0),
    .load_data (load_data),
    .pad_mask  ('0),
    .slot      (fill_slot)
  );

  window_bank #(
    .WIDTH     (WIDTH),
    .PAD_VALUE (PAD_VALUE)
  ) u_hold_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     ('0),
    .wr_data   ('0),
    .load      (transfer),
    .load_data (load_data),
    .pad_mask  (pad_mask_for(cnt_after)),
    .slot      (hold_slot)
  );

  assign win_valid  = win_valid_reg;
  assign win_count  = win_count_reg;
  assign win_data_0 = hold_slot[0];
  assign win_data_1 = hold_slot[1];
  assign win_data_2 = hold_slot[2];
  assign win_data_3 = hold_slot[3];
  assign win_data_4 = hold_slot[4];
  assign win_data_5 = hold_slot[5];

endmodule
